// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory stage.
// Provides the stage state encoding and the default ack timeout.
// Ports: none (package).
package mips_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int DEF_TIMEOUT = 16;

endpackage : mips_pkg

// File: rtl/mem_access_stage_if.sv
// Request/ack bus between the memory stage and the data memory.
// Request fields are held stable from issue until ack or abort; rdata is valid only with ack.
// Ports: master = stage side (drives request), slave = memory side (drives ack/rdata).
interface mem_access_stage_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface : mem_access_stage_if

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a memory ack; expire flags the last allowed cycle.
// Latency: expire is combinational from the count; count updates on the next edge.
// Ports: clk/rst, clear (sync zero), enable (increment), expire (count == TIMEOUT-1).
module mem_timeout_counter
   import mips_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = (cnt == LAST);

endmodule : mem_timeout_counter

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: runs a req/ack data-memory transaction for loads/stores and registers results for MEM/WB.
// Latency: 1 cycle for ALU ops, bubbles and misaligned accesses; >=2 cycles for memory ops (accept + ack).
// Backpressure: stall is raised combinationally while a transaction is outstanding and drops in the ack cycle.
// Ports: EX/MEM inputs (in_*, mem_read/mem_write), stall, memory bus (interface), MEM/WB outputs (out_*), error pulses.
module mem_access_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [31:0]                in_address,
   input  logic [31:0]                in_write_data,
   input  logic [31:0]                in_write_back,
   input  logic                       in_wb,
   output logic                       stall,
   mem_access_stage_if.master         bus,
   output logic                       out_valid,
   output logic [31:0]                out_read_data,
   output logic [31:0]                out_address,
   output logic [31:0]                out_write_back,
   output logic                       out_wb,
   output logic                       align_err,
   output logic                       bus_err
);

   localparam logic [0:0] S_IDLE   = IDLE;
   localparam logic [0:0] S_ACCESS = ACCESS;

   logic [0:0]  state;
   logic [31:0] lat_write_back;
   logic        lat_wb;
   logic        is_mem;
   logic        aligned;
   logic        expire;

   assign is_mem  = in_valid & (mem_read | mem_write);
   assign aligned = (in_address[1:0] == 2'b00);

   // In ACCESS the upstream is released in the ack cycle so it can advance on the same edge we retire.
   always_comb begin
      stall = 1'b0;
      if (state == S_IDLE) begin
         stall = is_mem & aligned;
      end else begin
         stall = ~bus.mem_ack;
      end
   end

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == S_IDLE),
      .enable ((state == S_ACCESS) & ~bus.mem_ack),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         lat_write_back <= '0;
         lat_wb         <= 1'b0;
         out_valid      <= 1'b0;
         out_read_data  <= '0;
         out_address    <= '0;
         out_write_back <= '0;
         out_wb         <= 1'b0;
         align_err      <= 1'b0;
         bus_err        <= 1'b0;
      end else begin
         align_err <= 1'b0;
         bus_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               // A stray ack here (late after timeout, or after reset) is deliberately ignored.
               if (!in_valid) begin
                  out_valid <= 1'b0;
                  out_wb    <= 1'b0;
               end else if (!is_mem) begin
                  out_valid      <= 1'b1;
                  out_read_data  <= '0;
                  out_address    <= in_address;
                  out_write_back <= in_write_back;
                  out_wb         <= in_wb;
               end else if (!aligned) begin
                  out_valid      <= 1'b1;
                  out_read_data  <= '0;
                  out_address    <= in_address;
                  out_write_back <= in_write_back;
                  out_wb         <= 1'b0;
                  align_err      <= 1'b1;
               end else begin
                  bus.mem_req    <= 1'b1;
                  // Read and write together behaves as a load.
                  bus.mem_we     <= mem_write & ~mem_read;
                  bus.mem_addr   <= in_address;
                  bus.mem_wdata  <= in_write_data;
                  lat_write_back <= in_write_back;
                  lat_wb         <= in_wb;
                  out_valid      <= 1'b0;
                  out_wb         <= 1'b0;
                  state          <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (bus.mem_ack) begin
                  bus.mem_req    <= 1'b0;
                  bus.mem_we     <= 1'b0;
                  out_valid      <= 1'b1;
                  out_read_data  <= bus.mem_we ? 32'h0 : bus.mem_rdata;
                  out_address    <= bus.mem_addr;
                  out_write_back <= lat_write_back;
                  out_wb         <= lat_wb;
                  state          <= S_IDLE;
               end else if (expire) begin
                  bus.mem_req    <= 1'b0;
                  bus.mem_we     <= 1'b0;
                  out_valid      <= 1'b1;
                  out_read_data  <= '0;
                  out_address    <= bus.mem_addr;
                  out_write_back <= lat_write_back;
                  out_wb         <= 1'b0;
                  bus_err        <= 1'b1;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: single-cycle vector table plus load/store/timeout/reset sequences.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, mem_read, mem_write, in_wb;
   logic [31:0] in_address, in_write_data, in_write_back;
   logic        stall, out_valid, out_wb, align_err, bus_err;
   logic [31:0] out_read_data, out_address, out_write_back;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .in_address     (in_address),
      .in_write_data  (in_write_data),
      .in_write_back  (in_write_back),
      .in_wb          (in_wb),
      .stall          (stall),
      .bus            (bus),
      .out_valid      (out_valid),
      .out_read_data  (out_read_data),
      .out_address    (out_address),
      .out_write_back (out_write_back),
      .out_wb         (out_wb),
      .align_err      (align_err),
      .bus_err        (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, rd, wr, wb;
      logic [31:0] addr, tag;
      logic        e_stall, e_valid, e_wb, e_align, e_req;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [31:0] tag, input logic wb);
      in_valid = v; mem_read = rd; mem_write = wr; in_address = addr;
      in_write_data = wdat; in_write_back = tag; in_wb = wb;
   endtask

   // Advance one edge and land 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0;

      //           v  rd wr wb addr          tag    stall val wb al req addr
      vecs[0] = '{1, 0, 0, 1, 32'h10,       32'hA, 0,    1,  1, 0, 0, 32'h10};
      vecs[1] = '{1, 1, 0, 1, 32'h102,      32'hB, 0,    1,  0, 1, 0, 32'h102};
      vecs[2] = '{0, 0, 0, 1, 32'h20,       32'hC, 0,    0,  0, 0, 0, 32'h102};
      vecs[3] = '{1, 0, 1, 0, 32'h201,      32'hD, 0,    1,  0, 1, 0, 32'h201};
      vecs[4] = '{1, 0, 0, 0, 32'hFFFFFFFC, 32'hE, 0,    1,  0, 0, 0, 32'hFFFFFFFC};
      vecs[5] = '{0, 1, 0, 1, 32'h40,       32'hF, 0,    0,  0, 0, 0, 32'hFFFFFFFC};
      vecs[6] = '{1, 1, 1, 1, 32'h3,        32'h1, 0,    1,  0, 1, 0, 32'h3};

      repeat (2) tick();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_wb", 32'(out_wb), 32'h0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_out_address", out_address, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      rst = 1'b0;

      // Single-cycle vectors: ALU ops, misaligned accesses, bubbles.
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].addr, 32'h55, vecs[i].tag, vecs[i].wb);
         #1;
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
         tick();
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d_out_wb", i), 32'(out_wb), 32'(vecs[i].e_wb));
         chk($sformatf("v%0d_align_err", i), 32'(align_err), 32'(vecs[i].e_align));
         chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
         chk($sformatf("v%0d_out_address", i), out_address, vecs[i].e_addr);
         if (vecs[i].e_valid)
            chk($sformatf("v%0d_out_read_data", i), out_read_data, 32'h0);
      end

      // Load with ack on the third ACCESS cycle.
      drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hC1, 1'b1);
      #1;
      chk("ld_stall_accept", 32'(stall), 32'h1);
      tick();
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("ld_req_c%0d", c), 32'(bus.mem_req), 32'h1);
         chk($sformatf("ld_addr_c%0d", c), bus.mem_addr, 32'h100);
         chk($sformatf("ld_we_c%0d", c), 32'(bus.mem_we), 32'h0);
         chk($sformatf("ld_stall_c%0d", c), 32'(stall), 32'h1);
         chk($sformatf("ld_valid_c%0d", c), 32'(out_valid), 32'h0);
         tick();
      end
      chk("ld_req_c2", 32'(bus.mem_req), 32'h1);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      #1;
      chk("ld_stall_ack", 32'(stall), 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      bus.mem_ack = 1'b0;
      chk("ld_req_done", 32'(bus.mem_req), 32'h0);
      chk("ld_valid", 32'(out_valid), 32'h1);
      chk("ld_rdata", out_read_data, 32'hDEADBEEF);
      chk("ld_wb", 32'(out_wb), 32'h1);
      chk("ld_address", out_address, 32'h100);
      chk("ld_tag", out_write_back, 32'hC1);
      tick();
      chk("ld_bubble_valid", 32'(out_valid), 32'h0);

      // Store with immediate ack.
      drive(1'b1, 1'b0, 1'b1, 32'h204, 32'h12345678, 32'hC2, 1'b0);
      tick();
      chk("st_req", 32'(bus.mem_req), 32'h1);
      chk("st_we", 32'(bus.mem_we), 32'h1);
      chk("st_wdata", bus.mem_wdata, 32'h12345678);
      chk("st_addr", bus.mem_addr, 32'h204);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hCAFEF00D;
      #1;
      chk("st_stall_ack", 32'(stall), 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      bus.mem_ack = 1'b0;
      chk("st_we_done", 32'(bus.mem_we), 32'h0);
      chk("st_req_done", 32'(bus.mem_req), 32'h0);
      chk("st_valid", 32'(out_valid), 32'h1);
      chk("st_rdata_zero", out_read_data, 32'h0);
      chk("st_tag", out_write_back, 32'hC2);

      // Read+write together behaves as a load.
      drive(1'b1, 1'b1, 1'b1, 32'h208, 32'h77, 32'hC3, 1'b1);
      tick();
      chk("rw_we", 32'(bus.mem_we), 32'h0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h0BADC0DE;
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      bus.mem_ack = 1'b0;
      chk("rw_rdata", out_read_data, 32'h0BADC0DE);

      // Timeout: 16 ACCESS cycles without ack, then a late ack that must be ignored.
      drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'hC4, 1'b1);
      tick();
      for (int c = 0; c < 15; c++) begin
         if (!bus.mem_req || bus_err || !stall)
            chk($sformatf("to_wait_c%0d", c), {29'h0, bus.mem_req, bus_err, stall}, 32'h5);
         tick();
      end
      chk("to_req_last", 32'(bus.mem_req), 32'h1);
      chk("to_no_err_early", 32'(bus_err), 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("to_bus_err", 32'(bus_err), 32'h1);
      chk("to_req_drop", 32'(bus.mem_req), 32'h0);
      chk("to_valid", 32'(out_valid), 32'h1);
      chk("to_wb", 32'(out_wb), 32'h0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h11111111;
      tick();
      bus.mem_ack = 1'b0;
      chk("late_bus_err", 32'(bus_err), 32'h0);
      chk("late_valid", 32'(out_valid), 32'h0);
      chk("late_req", 32'(bus.mem_req), 32'h0);

      // Reset in the second ACCESS cycle.
      drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 32'hC5, 1'b1);
      tick();
      tick();
      chk("rs_req_before", 32'(bus.mem_req), 32'h1);
      rst = 1'b1;
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("rs_req", 32'(bus.mem_req), 32'h0);
      chk("rs_stall", 32'(stall), 32'h0);
      chk("rs_valid", 32'(out_valid), 32'h0);
      chk("rs_bus_err", 32'(bus_err), 32'h0);
      chk("rs_rdata", out_read_data, 32'h0);
      chk("rs_addr", bus.mem_addr, 32'h0);
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rs_stale_ack_valid", 32'(out_valid), 32'h0);
      chk("rs_stale_ack_req", 32'(bus.mem_req), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mem_access_stage

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory stage of the 5-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register.
- Takes the EX/MEM outputs and runs a req/ack transaction to data memory for loads and stores.
- Stalls the front of the pipeline while a transaction is outstanding.
- Delivers registered readData/address/writeBack/WB to MEM/WB, plus alignment-error and bus-error flags.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ack before aborting with bus error (>=2).
- CNT_W, 5: width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- in_address  in  32  ALU result / effective address.
- in_write_data  in  32  store data (rt).
- in_write_back  in  32  writeback tag passed through to MEM/WB.
- in_wb  in  1  register-write enable.
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  request completed this cycle.
- mem_rdata  in  32  read data, valid with mem_ack.
- out_valid  out  1  output registers hold a retired instruction.
- out_read_data  out  32  load data (0 for non-loads).
- out_address  out  32  ALU result pass-through.
- out_write_back  out  32  tag pass-through.
- out_wb  out  1  register-write enable to MEM/WB.
- align_err  out  1  one-cycle pulse, misaligned access.
- bus_err  out  1  one-cycle pulse, ack timeout.

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counter 0.
- States: IDLE, ACCESS.
- Definitions:
  - is_mem = in_valid & (mem_read | mem_write)
  - aligned = (in_address[1:0] == 0)
  - mem_read & mem_write together is treated as a load.
- IDLE, non-memory valid instruction:
  - Next edge loads outputs: out_valid=1, out_read_data=0, out_address/out_write_back/out_wb from the inputs.
  - Latency 1, no stall.
- IDLE, is_mem & !aligned:
  - Next edge: out_valid=1, out_wb=0, align_err=1 for one cycle.
  - No mem_req is issued, no stall.
- IDLE, is_mem & aligned:
  - stall=1 combinationally.
  - Next edge latches mem_addr, mem_wdata, mem_we=mem_write, and the pass-through fields.
  - mem_req=1, counter=0, state->ACCESS, out_valid=0.
- ACCESS:
  - mem_req held at 1 and request fields stable until termination.
  - stall = !mem_ack (combinational), so upstream advances in the ack cycle.
  - Edge with mem_ack=1: mem_req=0, out_valid=1, out_read_data = mem_we ? 0 : mem_rdata, out_wb = latched in_wb, state->IDLE.
  - Edge with no ack and counter==TIMEOUT-1: mem_req=0, out_valid=1, out_wb=0, bus_err=1 for one cycle, state->IDLE.
  - Otherwise the counter increments.
  - Minimum load/store latency: 2 cycles (accept, then ack in the first ACCESS cycle).
- Bubbles: in_valid=0 in IDLE produces out_valid=0 and out_wb=0. out_valid=0 also holds throughout ACCESS.
- mem_ack in IDLE is ignored. This covers a stale ack after a timeout or reset.
- rst mid-ACCESS: next edge returns to IDLE and drops mem_req. In-flight data is discarded with no error pulse.
- Upstream holds its inputs stable while stall=1. The block does not re-sample them in ACCESS.

Decomposition:
- Shared package mips_pkg: state enum (IDLE, ACCESS) and a default TIMEOUT constant.
- One sub-module, mem_timeout_counter: clear/enable/expire with a CNT_W counter.
- Everything else stays flat.

Test Plan:
- ALU op: in_valid=1, in_address=0x10, in_wb=1, no mem -> next cycle out_valid=1, out_address=0x10, out_read_data=0, stall never high.
- Load, 3-cycle ack latency: mem_read at 0x100, mem_ack with rdata=0xDEADBEEF on the third ACCESS cycle -> mem_req high for 3 cycles, mem_addr=0x100, stall high until the ack cycle, then out_read_data=0xDEADBEEF, out_wb=1.
- Store, immediate ack: mem_write, addr=0x204, wdata=0x12345678 -> mem_we=1 and mem_wdata=0x12345678 for 1 cycle, out_read_data=0.
- Misaligned load at 0x102 -> mem_req never asserted, align_err one pulse, out_wb=0, no stall.
- Timeout: load with no ack, TIMEOUT=16 -> bus_err pulse after 16 ACCESS cycles, out_wb=0, mem_req drops. A late ack on the following cycle is ignored.
- rst asserted in the 2nd ACCESS cycle -> next cycle mem_req=0, stall=0, all outputs 0.
